// File: rtl/sign_ext_arbiter.sv
// Round-robin arbiter sharing one sign-extend datapath between two requesters, with a one-entry
// registered output. Define SEXT_SHIFT_EN to add per-port shift-left-1 (word-aligned offsets).
module sign_ext_arbiter #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             In0_Valid,
  input  logic [IN_W-1:0]  In0_Imm,
  output logic             In0_Ready,
  input  logic             In1_Valid,
  input  logic [IN_W-1:0]  In1_Imm,
  output logic             In1_Ready,
  output logic             Out_Valid,
  output logic [OUT_W-1:0] Out_Data,
  output logic             Out_Id,
  input  logic             Out_Ready
`ifdef SEXT_SHIFT_EN
  ,
  input  logic             In0_Shift,
  input  logic             In1_Shift
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             last_gnt_q, last_gnt_d;

  logic             free;
  logic             gnt0, gnt1;
  logic             rdy0, rdy1;
  logic [IN_W-1:0]  sel_imm;
  logic [OUT_W-1:0] ext;

  always_comb begin
    free = (state_q == StEmpty) | Out_Ready;
    // On a tie the port not served last wins; last_gnt_q=1 after reset favours port 0.
    gnt0 = In0_Valid & (~In1_Valid | last_gnt_q);
    gnt1 = In1_Valid & (~In0_Valid | ~last_gnt_q);
    rdy0 = free & gnt0 & ~Reset;
    rdy1 = free & gnt1 & ~Reset;

    sel_imm = rdy1 ? In1_Imm : In0_Imm;
`ifdef SEXT_SHIFT_EN
    if (rdy1 ? In1_Shift : In0_Shift) begin
      ext = {{(OUT_W-IN_W-1){sel_imm[IN_W-1]}}, sel_imm, 1'b0};
    end else begin
      ext = {{(OUT_W-IN_W){sel_imm[IN_W-1]}}, sel_imm};
    end
`else
    ext = {{(OUT_W-IN_W){sel_imm[IN_W-1]}}, sel_imm};
`endif

    state_d    = state_q;
    data_d     = data_q;
    id_d       = id_q;
    last_gnt_d = last_gnt_q;

    if (rdy0 | rdy1) begin
      state_d    = StFull;
      data_d     = ext;
      id_d       = rdy1;
      last_gnt_d = rdy1;
    end else if ((state_q == StFull) && Out_Ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StEmpty;
      data_q     <= '0;
      id_q       <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      id_q       <= id_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign In0_Ready = rdy0;
  assign In1_Ready = rdy1;
  assign Out_Valid = (state_q == StFull);
  assign Out_Data  = data_q;
  assign Out_Id    = id_q;

endmodule

// File: tb/tb_sign_ext_arbiter.sv
// Directed vector bench for sign_ext_arbiter; shift vectors are added when SEXT_SHIFT_EN is defined.
module tb_sign_ext_arbiter;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [11:0] i0;
    logic        s0;
    logic        v1;
    logic [11:0] i1;
    logic        s1;
    logic        ordy;
    logic        e_r0;
    logic        e_r1;
    logic        e_v;
    logic [15:0] e_d;
    logic        e_id;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        v0, v1, r0, r1;
  logic [11:0] i0, i1;
  logic        s0, s1;
  logic        ovalid, oid, ordy;
  logic [15:0] odata;

  int nvec;
  int nfail;
  vec_t vq[$];

  sign_ext_arbiter #(.IN_W(12), .OUT_W(16)) dut (
    .CLK       (clk),
    .Reset     (rst),
    .In0_Valid (v0),
    .In0_Imm   (i0),
    .In0_Ready (r0),
    .In1_Valid (v1),
    .In1_Imm   (i1),
    .In1_Ready (r1),
    .Out_Valid (ovalid),
    .Out_Data  (odata),
    .Out_Id    (oid),
    .Out_Ready (ordy)
`ifdef SEXT_SHIFT_EN
    ,
    .In0_Shift (s0),
    .In1_Shift (s1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rst_v, logic va, logic [11:0] ia, logic sa, logic vb,
                              logic [11:0] ib, logic sb, logic ordy_v, logic er0, logic er1,
                              logic ev, logic [15:0] ed, logic eid);
    vec_t t;
    t.rst = rst_v; t.v0 = va; t.i0 = ia; t.s0 = sa; t.v1 = vb; t.i1 = ib; t.s1 = sb;
    t.ordy = ordy_v; t.e_r0 = er0; t.e_r1 = er1; t.e_v = ev; t.e_d = ed; t.e_id = eid;
    return t;
  endfunction

  task automatic chk(input string name, input int k, input logic [15:0] act,
                     input logic [15:0] exp);
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int k);
    @(negedge clk);
    rst = t.rst; v0 = t.v0; i0 = t.i0; s0 = t.s0; v1 = t.v1; i1 = t.i1; s1 = t.s1;
    ordy = t.ordy;
    #1;
    nvec++;
    chk("in0_ready", k, {15'd0, r0}, {15'd0, t.e_r0});
    chk("in1_ready", k, {15'd0, r1}, {15'd0, t.e_r1});
    @(posedge clk);
    #1;
    chk("out_valid", k, {15'd0, ovalid}, {15'd0, t.e_v});
    chk("out_data", k, odata, t.e_d);
    chk("out_id", k, {15'd0, oid}, {15'd0, t.e_id});
  endtask

  initial begin
    nvec = 0; nfail = 0;
    rst = 1'b1; v0 = 0; v1 = 0; i0 = '0; i1 = '0; s0 = 0; s1 = 0; ordy = 0;

    //             rst v0 i0      s0 v1 i1      s1 ordy r0 r1 ov  data      id
    vq.push_back(mk(1, 1, 12'h7FF, 0, 0, 12'h000, 0, 1,  0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 12'h7FF, 0, 0, 12'h000, 0, 1,  1, 0, 1, 16'h07FF, 0));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 12'h800, 0, 1,  0, 1, 1, 16'hF800, 1));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 12'hFFF, 0, 1,  0, 1, 1, 16'hFFFF, 1));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 12'h000, 0, 1,  0, 1, 1, 16'h0000, 1));
    vq.push_back(mk(0, 1, 12'h001, 0, 1, 12'hFFE, 0, 1,  1, 0, 1, 16'h0001, 0));
    vq.push_back(mk(0, 1, 12'h001, 0, 1, 12'hFFE, 0, 1,  0, 1, 1, 16'hFFFE, 1));
    vq.push_back(mk(0, 1, 12'h001, 0, 1, 12'hFFE, 0, 1,  1, 0, 1, 16'h0001, 0));
    vq.push_back(mk(0, 1, 12'h001, 0, 1, 12'hFFE, 0, 1,  0, 1, 1, 16'hFFFE, 1));
    // Stall with both valid; port 0 changes its immediate while waiting.
    vq.push_back(mk(0, 1, 12'h001, 0, 1, 12'hFFE, 0, 0,  0, 0, 1, 16'hFFFE, 1));
    vq.push_back(mk(0, 1, 12'h123, 0, 1, 12'hFFE, 0, 0,  0, 0, 1, 16'hFFFE, 1));
    vq.push_back(mk(0, 1, 12'h123, 0, 1, 12'hFFE, 0, 0,  0, 0, 1, 16'hFFFE, 1));
    vq.push_back(mk(0, 1, 12'h456, 0, 1, 12'hFFE, 0, 1,  1, 0, 1, 16'h0456, 0));
    // Drain to EMPTY; data and id hold.
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 1,  0, 0, 0, 16'h0456, 0));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 0,  0, 0, 0, 16'h0456, 0));
    // EMPTY accepts even with Out_Ready low.
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 12'h00A, 0, 0,  0, 1, 1, 16'h000A, 1));
    vq.push_back(mk(0, 1, 12'h111, 0, 1, 12'h222, 0, 0,  0, 0, 1, 16'h000A, 1));
    // Reset with a free slot must still suppress both Ready.
    vq.push_back(mk(1, 1, 12'h111, 0, 1, 12'h222, 0, 1,  0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 12'h7FF, 0, 1, 12'h800, 0, 1,  1, 0, 1, 16'h07FF, 0));
    vq.push_back(mk(0, 1, 12'h100, 0, 0, 12'h000, 0, 1,  1, 0, 1, 16'h0100, 0));
    vq.push_back(mk(0, 1, 12'h100, 0, 1, 12'h801, 0, 1,  0, 1, 1, 16'hF801, 1));
    vq.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 0,  0, 0, 1, 16'hF801, 1));
`ifdef SEXT_SHIFT_EN
    vq.push_back(mk(0, 1, 12'h401, 1, 0, 12'h000, 0, 1,  1, 0, 1, 16'h0802, 0));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 12'hFFF, 1, 1,  0, 1, 1, 16'hFFFE, 1));
    vq.push_back(mk(0, 0, 12'h000, 0, 1, 12'hFFF, 0, 1,  0, 1, 1, 16'hFFFF, 1));
    vq.push_back(mk(0, 1, 12'h001, 0, 0, 12'h000, 1, 1,  1, 0, 1, 16'h0001, 0));
`endif

    foreach (vq[k]) apply(vq[k], k);

    // Long fairness run after reset: grants alternate 0,1,0,1... with one Ready per cycle.
    @(negedge clk);
    rst = 1'b1; v0 = 0; v1 = 0; s0 = 0; s1 = 0; ordy = 1;
    @(negedge clk);
    rst = 1'b0; v0 = 1; v1 = 1; i0 = 12'h801; i1 = 12'h07F;
    for (int c = 0; c < 8; c++) begin
      #1;
      nvec++;
      chk("alt_ready0", 100 + c, {15'd0, r0}, (c % 2 == 0) ? 16'd1 : 16'd0);
      chk("alt_ready1", 100 + c, {15'd0, r1}, (c % 2 == 1) ? 16'd1 : 16'd0);
      @(posedge clk);
      #1;
      chk("alt_id", 100 + c, {15'd0, oid}, (c % 2 == 0) ? 16'd0 : 16'd1);
      chk("alt_data", 100 + c, odata, (c % 2 == 0) ? 16'hF801 : 16'h007F);
      chk("alt_valid", 100 + c, {15'd0, ovalid}, 16'd1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
